// File: rtl/ua_receive_pkg.sv
// ============================================================================
// Module  : ua_receive_pkg
// Brief   : Shared frame constants, FSM encodings and log2 helper for the UART RX.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

package ua_receive_pkg;

    localparam int DATA_BITS = 8;
    localparam int STOP_BITS = 1;

    localparam logic [1:0] RX_IDLE  = 2'd0;
    localparam logic [1:0] RX_START = 2'd1;
    localparam logic [1:0] RX_DATA  = 2'd2;
    localparam logic [1:0] RX_STOP  = 2'd3;

    // Bits needed to hold values 0 .. value-1.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) begin
            result = result + 1;
        end
        return (result == 0) ? 1 : result;
    endfunction

endpackage : ua_receive_pkg

`default_nettype wire

// File: rtl/ua_receive_if.sv
// ============================================================================
// Module  : ua_receive_if
// Brief   : Ready/valid byte output bus plus error pulses of the UART receiver.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

interface ua_receive_if;
    import ua_receive_pkg::*;

    logic [DATA_BITS-1:0] DataOut;
    logic                 DataOutValid;
    logic                 DataOutReady;
    logic                 FramingError;
    logic                 Overrun;

    modport master (
        output DataOut,
        output DataOutValid,
        input  DataOutReady,
        output FramingError,
        output Overrun
    );

    modport slave (
        input  DataOut,
        input  DataOutValid,
        output DataOutReady,
        input  FramingError,
        input  Overrun
    );

endinterface : ua_receive_if

`default_nettype wire

// File: rtl/ua_receive_sync.sv
// ============================================================================
// Module  : sync_2ff
// Brief   : Parameterised-width two-flop synchroniser, async active-low reset.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module sync_2ff #(
    parameter int               WIDTH     = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '1
) (
    input  logic             Clock,
    input  logic             Reset_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] r_meta;
    logic [WIDTH-1:0] r_sync;

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            r_meta <= RESET_VAL;
            r_sync <= RESET_VAL;
        end else begin
            r_meta <= d;
            r_sync <= r_meta;
        end
    end

    assign q = r_sync;

endmodule : sync_2ff

`default_nettype wire

// File: rtl/ua_receive.sv
// ============================================================================
// Module  : ua_receive
// Brief   : UART 8N1 receiver, LSB first, bytes out on a ready/valid port.
//           Define UART_RX_MAJORITY_EN for 2-of-3 voting around each sample.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module ua_receive
    import ua_receive_pkg::*;
#(
    parameter int CLOCK_FREQ = 100_000_000,
    parameter int BAUD_RATE  = 115_200
) (
    input  logic          Clock,
    input  logic          Reset_n,
    input  logic          SIn,
    ua_receive_if.master  rx_bus
);

    localparam int c_symbol = CLOCK_FREQ / BAUD_RATE;
    localparam int c_sample = c_symbol / 2;
    localparam int c_cw     = clog2(c_symbol);

`ifdef UART_RX_MAJORITY_EN
    localparam logic [c_cw-1:0] c_start_pt = c_cw'(c_sample);
`else
    localparam logic [c_cw-1:0] c_start_pt = c_cw'(c_sample - 1);
`endif
    // Data/stop decisions are one full symbol apart, so any start-point shift carries through.
    localparam logic [c_cw-1:0] c_data_pt = c_cw'(c_symbol - 1);
    localparam logic [2:0]      c_last_bit = 3'(DATA_BITS - 1);

    logic                 w_rx;
    logic                 r_rx_prev;
    logic [1:0]           r_state;
    logic [c_cw-1:0]      r_count;
    logic [2:0]           r_bitcnt;
    logic [DATA_BITS-1:0] r_shift;
    logic [DATA_BITS-1:0] r_data;
    logic                 r_valid;
    logic                 r_ferr;
    logic                 r_ovr;
    logic [c_cw-1:0]      w_point;
    logic                 w_at_point;
    logic                 w_bit;

    sync_2ff #(
        .WIDTH     (1),
        .RESET_VAL (1'b1)
    ) u_sync (
        .Clock   (Clock),
        .Reset_n (Reset_n),
        .d       (SIn),
        .q       (w_rx)
    );

    always_comb begin
        w_point    = (r_state == RX_START) ? c_start_pt : c_data_pt;
        w_at_point = (r_count == w_point);
    end

`ifdef UART_RX_MAJORITY_EN
    logic [1:0] r_vote;

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            r_vote <= 2'b11;
        end else begin
            if (r_count == (w_point - c_cw'(2))) r_vote[0] <= w_rx;
            if (r_count == (w_point - c_cw'(1))) r_vote[1] <= w_rx;
        end
    end

    assign w_bit = (r_vote[0] & r_vote[1]) | (r_vote[0] & w_rx) | (r_vote[1] & w_rx);
`else
    assign w_bit = w_rx;
`endif

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            r_rx_prev <= 1'b1;
            r_state   <= RX_IDLE;
            r_count   <= '0;
            r_bitcnt  <= '0;
            r_shift   <= '0;
            r_data    <= '0;
            r_valid   <= 1'b0;
            r_ferr    <= 1'b0;
            r_ovr     <= 1'b0;
        end else begin
            r_rx_prev <= w_rx;
            r_ferr    <= 1'b0;
            r_ovr     <= 1'b0;
            if (r_valid && rx_bus.DataOutReady) r_valid <= 1'b0;

            case (r_state)
                RX_IDLE: begin
                    if (r_rx_prev && !w_rx) begin
                        r_state <= RX_START;
                        r_count <= '0;
                    end
                end
                RX_START: begin
                    if (w_at_point) begin
                        r_count  <= '0;
                        r_bitcnt <= '0;
                        r_state  <= w_bit ? RX_IDLE : RX_DATA;
                    end else begin
                        r_count <= r_count + c_cw'(1);
                    end
                end
                RX_DATA: begin
                    if (w_at_point) begin
                        r_count           <= '0;
                        r_shift[r_bitcnt] <= w_bit;
                        if (r_bitcnt == c_last_bit) r_state  <= RX_STOP;
                        else                        r_bitcnt <= r_bitcnt + 3'd1;
                    end else begin
                        r_count <= r_count + c_cw'(1);
                    end
                end
                RX_STOP: begin
                    if (w_at_point) begin
                        r_count <= '0;
                        r_state <= RX_IDLE;
                        if (!w_bit) begin
                            r_ferr <= 1'b1;
                        end else if (!r_valid || rx_bus.DataOutReady) begin
                            // A same-cycle consume frees the buffer, so the new byte lands.
                            r_data  <= r_shift;
                            r_valid <= 1'b1;
                        end else begin
                            r_ovr <= 1'b1;
                        end
                    end else begin
                        r_count <= r_count + c_cw'(1);
                    end
                end
                default: r_state <= RX_IDLE;
            endcase
        end
    end

    assign rx_bus.DataOut      = r_data;
    assign rx_bus.DataOutValid = r_valid;
    assign rx_bus.FramingError = r_ferr;
    assign rx_bus.Overrun      = r_ovr;

endmodule : ua_receive

`default_nettype wire

// File: tb/tb_ua_receive.sv
// ============================================================================
// Module  : tb_ua_receive
// Brief   : Directed self-checking bench for ua_receive at 868 clocks per bit.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module tb_ua_receive;

    localparam int c_bit = 868;
`ifdef UART_RX_MAJORITY_EN
    localparam bit c_spike = 1'b1;
`else
    localparam bit c_spike = 1'b0;
`endif

    logic Clock;
    logic Reset_n;
    logic SIn;

    ua_receive_if rx_if ();

    ua_receive u_dut (
        .Clock   (Clock),
        .Reset_n (Reset_n),
        .SIn     (SIn),
        .rx_bus  (rx_if.master)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    int         n_checks = 0;
    int         n_pass   = 0;
    logic [7:0] rcv_q[$];
    int         n_valid_cyc = 0;
    int         n_ferr = 0;
    int         n_ovr  = 0;

    always @(negedge Clock) begin
        if (Reset_n) begin
            if (rx_if.DataOutValid) n_valid_cyc++;
            if (rx_if.DataOutValid && rx_if.DataOutReady) rcv_q.push_back(rx_if.DataOut);
            if (rx_if.FramingError) n_ferr++;
            if (rx_if.Overrun) n_ovr++;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    endtask

    task automatic clear_mon();
        rcv_q.delete();
        n_valid_cyc = 0;
        n_ferr      = 0;
        n_ovr       = 0;
    endtask

    function automatic logic [31:0] rcv_at(input int idx);
        return (idx < rcv_q.size()) ? {24'd0, rcv_q[idx]} : 32'hDEAD;
    endfunction

    task automatic cycles(input int n);
        repeat (n) begin
            @(posedge Clock);
            #1;
        end
    endtask

    // One bit period; the optional spike lands on the central vote sample.
    task automatic drive_bit(input logic b, input bit spike);
        for (int i = 0; i < c_bit; i++) begin
            SIn = (spike && i == 433) ? ~b : b;
            @(posedge Clock);
            #1;
        end
        SIn = b;
    endtask

    task automatic send_byte(input logic [7:0] data, input logic stop, input bit spike);
        drive_bit(1'b0, 1'b0);
        for (int k = 0; k < 8; k++) drive_bit(data[k], spike);
        drive_bit(stop, 1'b0);
        SIn = 1'b1;
    endtask

    initial begin
        Reset_n = 1'b0;
        SIn     = 1'b1;
        rx_if.DataOutReady = 1'b1;
        cycles(5);
        @(negedge Clock);
        check("reset_valid", {31'd0, rx_if.DataOutValid}, 32'd0);
        check("reset_data",  {24'd0, rx_if.DataOut},      32'h00);
        check("reset_ferr",  {31'd0, rx_if.FramingError}, 32'd0);
        check("reset_ovr",   {31'd0, rx_if.Overrun},      32'd0);
        @(posedge Clock);
        #1;
        Reset_n = 1'b1;
        cycles(20);

        clear_mon();
        send_byte(8'hA5, 1'b1, 1'b0);
        cycles(c_bit);
        check("a5_count",  rcv_q.size(), 32'd1);
        check("a5_data",   rcv_at(0),    32'hA5);
        check("a5_vcyc",   n_valid_cyc,  32'd1);
        check("a5_ferr",   n_ferr,       32'd0);
        check("a5_ovr",    n_ovr,        32'd0);

        clear_mon();
        SIn = 1'b0;
        cycles(200);
        SIn = 1'b1;
        cycles(12 * c_bit);
        check("glitch_count", rcv_q.size(), 32'd0);
        check("glitch_vcyc",  n_valid_cyc,  32'd0);
        check("glitch_ferr",  n_ferr,       32'd0);

        clear_mon();
        send_byte(8'h3C, 1'b0, 1'b0);
        cycles(2 * c_bit);
        check("ferr_pulse", n_ferr,       32'd1);
        check("ferr_vcyc",  n_valid_cyc,  32'd0);
        check("ferr_count", rcv_q.size(), 32'd0);
        send_byte(8'h7E, 1'b1, 1'b0);
        cycles(c_bit);
        check("after_ferr_count", rcv_q.size(), 32'd1);
        check("after_ferr_data",  rcv_at(0),    32'h7E);
        check("after_ferr_ferr",  n_ferr,       32'd1);

        clear_mon();
        rx_if.DataOutReady = 1'b0;
        send_byte(8'h11, 1'b1, 1'b0);
        cycles(c_bit);
        send_byte(8'h22, 1'b1, 1'b0);
        cycles(c_bit);
        @(negedge Clock);
        check("ovr_valid", {31'd0, rx_if.DataOutValid}, 32'd1);
        check("ovr_data",  {24'd0, rx_if.DataOut},      32'h11);
        check("ovr_pulse", n_ovr,  32'd1);
        check("ovr_ferr",  n_ferr, 32'd0);
        @(posedge Clock);
        #1;
        rx_if.DataOutReady = 1'b1;
        cycles(3);
        @(negedge Clock);
        check("ovr_drain_count", rcv_q.size(), 32'd1);
        check("ovr_drain_data",  rcv_at(0),    32'h11);
        check("ovr_drain_valid", {31'd0, rx_if.DataOutValid}, 32'd0);
        @(posedge Clock);
        #1;

        clear_mon();
        send_byte(8'h00, 1'b1, c_spike);
        send_byte(8'hFF, 1'b1, c_spike);
        send_byte(8'h55, 1'b1, c_spike);
        cycles(c_bit);
        check("b2b_count", rcv_q.size(), 32'd3);
        check("b2b_0",     rcv_at(0),    32'h00);
        check("b2b_1",     rcv_at(1),    32'hFF);
        check("b2b_2",     rcv_at(2),    32'h55);
        check("b2b_err",   n_ferr + n_ovr, 32'd0);

        clear_mon();
        drive_bit(1'b0, 1'b0);
        drive_bit(1'b1, 1'b0);
        drive_bit(1'b1, 1'b0);
        Reset_n = 1'b0;
        cycles(3);
        @(negedge Clock);
        check("midrst_valid", {31'd0, rx_if.DataOutValid}, 32'd0);
        check("midrst_data",  {24'd0, rx_if.DataOut},      32'h00);
        @(posedge Clock);
        #1;
        Reset_n = 1'b1;
        SIn     = 1'b1;
        cycles(12 * c_bit);
        check("midrst_count", rcv_q.size(), 32'd0);
        check("midrst_ferr",  n_ferr,       32'd0);
        check("midrst_ovr",   n_ovr,        32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_ua_receive

`default_nettype wire
